filter_mux_sched: RTL and testbench

- Time-multiplexed controller for the 4-tap moving-average datapath: one averaging engine serves N_CH sample sources.
- Round-robin arbitration between per-channel sample requests; per-channel 4-deep history and running sum.
- Emits the windowed mean, tagged with its channel, one grant per 2 clocks.
- Sits between the ADC capture front-ends and the per-channel display/processing logic.

---
 rtl/filter_mux_sched.sv | 144 ++++++++++++++
 tb/tb_filter_mux_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mux_sched.sv
// Time-multiplexed 4-tap moving-average engine shared by N_CH sample sources.
// Round-robin grant in IDLE, per-channel window update and mean output in CALC.
module filter_mux_sched #(
    parameter int N_CH      = 4,
    parameter int W         = 10,
    parameter int TAPS_LOG2 = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_CH-1:0]   req_i,
    input  logic [N_CH*W-1:0] sample_i,
    input  logic              flush_i,
    output logic [N_CH-1:0]   ack_o,
    output logic [W-1:0]      data_o,
    output logic [1:0]        chan_o,
    output logic              valid_o,
    output logic              primed_o
);

    localparam int TAPS  = 1 << TAPS_LOG2;
    localparam int SW    = W + TAPS_LOG2;
    localparam int CW    = 2;
    localparam int CNT_W = TAPS_LOG2 + 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] CNT_PRIME = CNT_W'(TAPS - 1);
    localparam logic [CW-1:0]    LAST_CH   = CW'(N_CH - 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]        last_g;
    logic [CW-1:0]        g_q;
    logic [W-1:0]         smp_q;
    logic [W-1:0]         hist [N_CH][TAPS];
    logic [SW-1:0]        sum  [N_CH];
    logic [TAPS_LOG2-1:0] wp   [N_CH];
    logic [CNT_W-1:0]     cnt  [N_CH];

    logic                 grant_hit;
    logic [CW-1:0]        grant_idx;
    logic [W-1:0]         oldest;
    logic [SW-1:0]        new_sum;
    logic [CNT_W-1:0]     new_cnt;

    // Rotating priority search starting just after the last granted channel.
    // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = last_g;
        for (int i = 1; i <= N_CH; i++) begin
            logic [CW-1:0] cand;
            cand = CW'((int'(last_g) + i) % N_CH);
            if (!grant_hit && req_i[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Oldest tap is always a term of the running sum, so the subtract is exact.
    always_comb begin
        oldest  = hist[g_q][wp[g_q]];
        new_sum = sum[g_q] - SW'(oldest) + SW'(smp_q);
        new_cnt = (cnt[g_q] == CNT_FULL) ? cnt[g_q] : cnt[g_q] + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (grant_hit) state_d = CALC;
                CALC:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: histories are reset explicitly because an unprimed window must read as zeros.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_g   <= LAST_CH;
            g_q      <= '0;
            smp_q    <= '0;
            ack_o    <= '0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            chan_o   <= '0;
            primed_o <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                sum[k] <= '0;
                wp[k]  <= '0;
                cnt[k] <= '0;
                for (int t = 0; t < TAPS; t++) hist[k][t] <= '0;
            end
        end else if (flush_i) begin
            ack_o   <= '0;
            valid_o <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                sum[k] <= '0;
                wp[k]  <= '0;
                cnt[k] <= '0;
                for (int t = 0; t < TAPS; t++) hist[k][t] <= '0;
            end
        end else begin
            ack_o   <= '0;
            valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_hit) begin
                        g_q    <= grant_idx;
                        smp_q  <= sample_i[int'(grant_idx)*W +: W];
                        ack_o  <= N_CH'(1) << grant_idx;
                        last_g <= grant_idx;
                    end
                end
                CALC: begin
                    sum[g_q]          <= new_sum;
                    hist[g_q][wp[g_q]] <= smp_q;
                    wp[g_q]           <= wp[g_q] + TAPS_LOG2'(1);
                    cnt[g_q]          <= new_cnt;
                    data_o            <= new_sum[SW-1:TAPS_LOG2];
                    chan_o            <= g_q;
                    primed_o          <= (cnt[g_q] >= CNT_PRIME);
                    valid_o           <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_mux_sched.sv
// Randomized scoreboard bench for filter_mux_sched: a window-of-4 reference model
// predicts grants and means; a monitor pops and compares whenever the DUT strobes.
module tb_filter_mux_sched;

    localparam int N_CH = 4;
    localparam int W    = 10;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N_CH-1:0]   req_i;
    logic [N_CH*W-1:0] sample_i;
    logic              flush_i;
    logic [N_CH-1:0]   ack_o;
    logic [W-1:0]      data_o;
    logic [1:0]        chan_o;
    logic              valid_o;
    logic              primed_o;

    filter_mux_sched #(.N_CH(N_CH), .W(W), .TAPS_LOG2(2)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .sample_i (sample_i),
        .flush_i  (flush_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .chan_o   (chan_o),
        .valid_o  (valid_o),
        .primed_o (primed_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Per-channel sources: each queue holds the samples that requester still has to send.
    int chq [N_CH][$];

    initial begin
        req_i    = '0;
        sample_i = '0;
        forever begin
            @(negedge clk_i);
            for (int k = 0; k < N_CH; k++)
                if (ack_o[k]) req_i[k] = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                if (rst_ni && !req_i[k] && chq[k].size() > 0) begin
                    sample_i[k*W +: W] = W'(chq[k].pop_front());
                    req_i[k] = 1'b1;
                end
            end
        end
    end

    // Reference model: each channel keeps its last four samples (oldest first).
    typedef struct {
        int ch;
        int data;
        int primed;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   m_win [N_CH][4];
    int   m_cnt [N_CH];
    int   m_last = N_CH - 1;
    bit   m_busy = 1'b0;
    exp_t pend;

    task automatic model_clear_hist();
        for (int k = 0; k < N_CH; k++) begin
            m_cnt[k] = 0;
            for (int j = 0; j < 4; j++) m_win[k][j] = 0;
        end
    endtask

    task automatic model_step();
        int g;
        int s;
        int total_sum;
        if (flush_i) begin
            model_clear_hist();
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_busy = 1'b0;
            exp_q.push_back(pend);
        end else if (req_i != '0) begin
            g = -1;
            for (int i = 1; i <= N_CH; i++) begin
                int c;
                c = (m_last + i) % N_CH;
                if (g < 0 && req_i[c]) g = c;
            end
            m_last = g;
            ack_q.push_back(g);
            s = int'(sample_i[g*W +: W]);
            for (int j = 0; j < 3; j++) m_win[g][j] = m_win[g][j+1];
            m_win[g][3] = s;
            m_cnt[g]++;
            total_sum = 0;
            for (int j = 0; j < 4; j++) total_sum += m_win[g][j];
            pend.ch     = g;
            pend.data   = total_sum / 4;
            pend.primed = (m_cnt[g] >= 4) ? 1 : 0;
            m_busy = 1'b1;
        end
    endtask

    initial model_clear_hist();

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            model_clear_hist();
            m_last = N_CH - 1;
            m_busy = 1'b0;
            exp_q.delete();
            ack_q.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: compares on every ack/valid strobe and flags strobes that never came.
    int cyc     = 0;
    int ack_cyc = -10;

    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_ni) begin
                if (ack_o != '0) begin
                    if (ack_q.size() == 0) begin
                        check("unexpected_ack", int'(ack_o), 0);
                    end else begin
                        check("ack_onehot", int'(ack_o), 1 << ack_q.pop_front());
                        ack_cyc = cyc;
                    end
                end else if (ack_q.size() > 0) begin
                    check("ack_missing", int'(ack_o), 1 << ack_q.pop_front());
                end

                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", int'(valid_o), 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("chan", int'(chan_o), e.ch);
                        check("data", int'(data_o), e.data);
                        check("primed", int'(primed_o), e.primed);
                        check("valid_latency", cyc - ack_cyc, 1);
                    end
                end else if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    check("valid_missing", int'(valid_o), 1);
                end
            end
        end
    end

    function automatic bit busy();
        bit b;
        b = (req_i != '0) || m_busy || (ack_q.size() > 0) || (exp_q.size() > 0);
        for (int k = 0; k < N_CH; k++)
            if (chq[k].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy() && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        check(name, int'(n < 3000), 1);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic flush_pulse();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (ack_o == '0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check(name, int'(ack_o != '0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        flush_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ack", int'(ack_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_data", int'(data_o), 0);
        check("rst_chan", int'(chan_o), 0);
        check("rst_primed", int'(primed_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // All four requesting together, then ch0 and ch2 again.
        for (int k = 0; k < N_CH; k++) chq[k].push_back(10 * (k + 1));
        wait_idle("drain_rr4");
        chq[0].push_back(7);
        chq[2].push_back(9);
        wait_idle("drain_rr2");

        // Ch0 alone on a clean window.
        flush_pulse();
        for (int i = 1; i <= 5; i++) chq[0].push_back(100 * i);
        wait_idle("drain_ch0");

        // Ch1 at full scale.
        for (int i = 0; i < 6; i++) chq[1].push_back(1023);
        wait_idle("drain_full");

        // Interleaved ch0 / ch3.
        flush_pulse();
        for (int i = 0; i < 4; i++) begin
            chq[0].push_back(40);
            chq[3].push_back(8);
        end
        wait_idle("drain_interleave");

        // Flush restarts a primed window.
        for (int i = 0; i < 4; i++) chq[2].push_back(400);
        wait_idle("drain_prime2");
        flush_pulse();
        chq[2].push_back(400);
        wait_idle("drain_after_flush");

        // Flush during CALC discards the transaction.
        chq[1].push_back(600);
        wait_ack("ack_before_flush");
        flush_i = 1'b1;
        @(negedge clk_i);
        check("no_valid_after_calc_flush", int'(valid_o), 0);
        flush_i = 1'b0;
        wait_idle("drain_calc_flush");

        // Flush with a request pending in IDLE: no grant that edge.
        @(negedge clk_i);
        flush_i = 1'b1;
        chq[3].push_back(300);
        @(negedge clk_i);
        check("no_ack_on_flush", int'(ack_o), 0);
        flush_i = 1'b0;
        wait_idle("drain_idle_flush");

        // Asynchronous reset while ack_o is high, then while valid_o is high.
        chq[1].push_back(500);
        wait_ack("ack_before_reset");
        #1 rst_ni = 1'b0;
        #1;
        check("reset_drops_ack", int'(ack_o), 0);
        check("reset_valid_low", int'(valid_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chq[2].push_back(100);
        wait_ack("ack_before_reset2");
        @(negedge clk_i);
        check("valid_before_reset", int'(valid_o), 1);
        #1 rst_ni = 1'b0;
        #1;
        check("reset_drops_valid", int'(valid_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chq[0].push_back(40);
        chq[3].push_back(80);
        wait_idle("drain_after_reset");

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 160; n++) begin
            int ch;
            int v;
            ch = int'($urandom_range(0, N_CH - 1));
            case ($urandom_range(0, 5))
                0:       v = 0;
                1:       v = 1023;
                default: v = int'($urandom_range(0, 1023));
            endcase
            chq[ch].push_back(v);
            if ($urandom_range(0, 2) == 0) @(negedge clk_i);
            if ($urandom_range(0, 24) == 0) flush_pulse();
        end
        wait_idle("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
